// File: rtl/fsm_datapath.sv
// -----------------------------------------------------------------------------
// fsm_datapath
//
// Execute/writeback stage sitting downstream of the sequencing FSM. Each clock
// it reads two operands from a 16 x 16-bit register file (or an immediate for
// B), performs one ALU operation and, when the result bus is enabled, writes
// the result into every register selected by regs_en. It also keeps the
// {N,Z,F,L,C} status register and a display latch holding the last value
// written to any register.
//
// Ports
//   clk          system clock, all state updates on posedge
//   reset        asynchronous, active-high; clears registers, flags, display
//   alu_op       operation code (AND/OR/XOR/ADD/SUB/CMP/MOV/LSH)
//   muxA, muxB   operand register selects; codes 16-31 read as zero
//   regs_en      per-register write enables, bit i writes Ri
//   imm          immediate operand
//   imm_control  1 = B operand is imm, 0 = B operand is R[muxB]
//   buff_en      result-bus enable; gates writeback and flag updates
//   bus_out      combinational result bus (0 when buff_en = 0)
//   flags        status register {N,Z,F,L,C}
//   disp_value   last value written to any register
// -----------------------------------------------------------------------------
module fsm_datapath #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       alu_op,
    input  logic [4:0]       muxA,
    input  logic [4:0]       muxB,
    input  logic [NREGS-1:0] regs_en,
    input  logic [WIDTH-1:0] imm,
    input  logic             imm_control,
    input  logic             buff_en,
    output logic [WIDTH-1:0] bus_out,
    output logic [4:0]       flags,
    output logic [WIDTH-1:0] disp_value
);

    typedef enum logic [7:0] {
        OP_AND = 8'h01,
        OP_OR  = 8'h02,
        OP_XOR = 8'h03,
        OP_ADD = 8'h05,
        OP_SUB = 8'h09,
        OP_CMP = 8'h0B,
        OP_MOV = 8'h0D,
        OP_LSH = 8'h84
    } op_e;

    // Bit positions inside flags = {N,Z,F,L,C}
    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_C = 0;

    logic [WIDTH-1:0] regs [NREGS];

    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] b_val;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] result;
    logic             op_valid;
    logic             writes_reg;
    logic [4:0]       flags_next;

    // Operand fetch and ALU. Reads see the register contents before the
    // current edge, so a write in cycle n is visible to reads in cycle n+1.
    // NOTE: every output of this block gets a default first so no path
    // through the case statement leaves a signal unassigned (no latches).
    always_comb begin
        a_val      = muxA[4] ? '0 : regs[muxA[3:0]];
        b_reg      = muxB[4] ? '0 : regs[muxB[3:0]];
        b_val      = imm_control ? imm : b_reg;
        // One extra bit captures carry out of ADD and borrow out of SUB.
        sum        = {1'b0, a_val} + {1'b0, b_val};
        diff       = {1'b0, a_val} - {1'b0, b_val};

        result     = '0;
        op_valid   = 1'b0;
        writes_reg = 1'b0;
        flags_next = flags;

        case (alu_op)
            OP_AND: begin
                result     = a_val & b_val;
                op_valid   = 1'b1;
                writes_reg = 1'b1;
                flags_next[FLAG_Z] = ((a_val & b_val) == '0);
            end
            OP_OR: begin
                result     = a_val | b_val;
                op_valid   = 1'b1;
                writes_reg = 1'b1;
                flags_next[FLAG_Z] = ((a_val | b_val) == '0);
            end
            OP_XOR: begin
                result     = a_val ^ b_val;
                op_valid   = 1'b1;
                writes_reg = 1'b1;
                flags_next[FLAG_Z] = ((a_val ^ b_val) == '0);
            end
            OP_ADD: begin
                result     = sum[WIDTH-1:0];
                op_valid   = 1'b1;
                writes_reg = 1'b1;
                flags_next[FLAG_C] = sum[WIDTH];
                // Overflow: operands share a sign that the result does not.
                flags_next[FLAG_F] = (a_val[WIDTH-1] == b_val[WIDTH-1]) &&
                                     (sum[WIDTH-1] != a_val[WIDTH-1]);
                flags_next[FLAG_Z] = (sum[WIDTH-1:0] == '0);
            end
            OP_SUB: begin
                result     = diff[WIDTH-1:0];
                op_valid   = 1'b1;
                writes_reg = 1'b1;
                flags_next[FLAG_C] = diff[WIDTH];
                // Overflow: operand signs differ and result sign differs from A.
                flags_next[FLAG_F] = (a_val[WIDTH-1] != b_val[WIDTH-1]) &&
                                     (diff[WIDTH-1] != a_val[WIDTH-1]);
                flags_next[FLAG_Z] = (diff[WIDTH-1:0] == '0);
            end
            OP_CMP: begin
                // Result still appears on the bus, but no register is written.
                result     = diff[WIDTH-1:0];
                op_valid   = 1'b1;
                flags_next[FLAG_Z] = (a_val == b_val);
                flags_next[FLAG_L] = (a_val < b_val);
                flags_next[FLAG_N] = ($signed(a_val) < $signed(b_val));
            end
            OP_MOV: begin
                result     = b_val;
                op_valid   = 1'b1;
                writes_reg = 1'b1;
                flags_next[FLAG_Z] = (b_val == '0);
            end
            OP_LSH: begin
                result     = a_val << b_val[3:0];
                op_valid   = 1'b1;
                writes_reg = 1'b1;
                flags_next[FLAG_Z] = ((a_val << b_val[3:0]) == '0);
            end
            default: ;
        endcase
    end

    assign bus_out = buff_en ? result : '0;

    // Gating on buff_en first keeps X on other controls away from state
    // while the bus is disabled.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, which is what gives read-old-value semantics.
    // NOTE: the register file is a flop array that must read as zero after
    // reset, so it is cleared explicitly rather than left to power-up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            flags      <= '0;
            disp_value <= '0;
        end else if (buff_en && op_valid) begin
            flags <= flags_next;
            if (writes_reg) begin
                for (int i = 0; i < NREGS; i++) begin
                    if (regs_en[i]) begin
                        regs[i] <= result;
                    end
                end
                if (|regs_en) begin
                    disp_value <= result;
                end
            end
        end
    end

endmodule

// File: tb/tb_fsm_datapath.sv
// -----------------------------------------------------------------------------
// tb_fsm_datapath
//
// Directed testbench for fsm_datapath. Controls are driven on negedge (as the
// upstream FSM does) and results sampled 1 ns after posedge. Register contents
// are observed through bus_out with a MOV of the register, never written back.
// -----------------------------------------------------------------------------
module tb_fsm_datapath;

    localparam logic [7:0] OP_AND = 8'h01;
    localparam logic [7:0] OP_OR  = 8'h02;
    localparam logic [7:0] OP_XOR = 8'h03;
    localparam logic [7:0] OP_ADD = 8'h05;
    localparam logic [7:0] OP_SUB = 8'h09;
    localparam logic [7:0] OP_CMP = 8'h0B;
    localparam logic [7:0] OP_MOV = 8'h0D;
    localparam logic [7:0] OP_LSH = 8'h84;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  alu_op;
    logic [4:0]  muxA;
    logic [4:0]  muxB;
    logic [15:0] regs_en;
    logic [15:0] imm;
    logic        imm_control;
    logic        buff_en;
    logic [15:0] bus_out;
    logic [4:0]  flags;
    logic [15:0] disp_value;

    int n_checks = 0;
    int n_fail   = 0;

    fsm_datapath #(.WIDTH(16), .NREGS(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_op      (alu_op),
        .muxA        (muxA),
        .muxB        (muxB),
        .regs_en     (regs_en),
        .imm         (imm),
        .imm_control (imm_control),
        .buff_en     (buff_en),
        .bus_out     (bus_out),
        .flags       (flags),
        .disp_value  (disp_value)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        alu_op      = 8'h00;
        muxA        = 5'd0;
        muxB        = 5'd0;
        regs_en     = 16'h0000;
        imm         = 16'h0000;
        imm_control = 1'b0;
        buff_en     = 1'b0;
    endtask

    // One operation: drive on negedge, capture bus before the edge, let the
    // posedge execute, then return to idle 1 ns after the edge.
    task automatic do_op(input logic [7:0] op, input logic [4:0] ma, input logic [4:0] mb,
                         input logic [15:0] en, input logic [15:0] im, input logic ic,
                         input logic be, output logic [15:0] bus_seen);
        @(negedge clk);
        alu_op      = op;
        muxA        = ma;
        muxB        = mb;
        regs_en     = en;
        imm         = im;
        imm_control = ic;
        buff_en     = be;
        #1 bus_seen = bus_out;
        @(posedge clk);
        #1 drive_idle();
    endtask

    // Reads a register through the bus; controls return to idle before the
    // next posedge so no state changes.
    task automatic peek_reg(input int idx, output logic [15:0] val);
        @(negedge clk);
        alu_op      = OP_MOV;
        muxB        = 5'(idx);
        imm_control = 1'b0;
        regs_en     = 16'h0000;
        buff_en     = 1'b1;
        #1 val = bus_out;
        drive_idle();
    endtask

    task automatic test_reset();
        logic [15:0] v;
        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (flags !== 5'b00000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected %b", flags, 5'b00000);
        end
        n_checks++;
        if (disp_value !== 16'h0000) begin
            n_fail++; $display("FAIL reset_disp: got %h expected %h", disp_value, 16'h0000);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            peek_reg(i, v);
            n_checks++;
            if (v !== 16'h0000) begin
                n_fail++; $display("FAIL reset_reg R%0d: got %h expected %h", i, v, 16'h0000);
            end
        end
    endtask

    task automatic test_fibonacci();
        logic [15:0] fib [16];
        logic [15:0] bus;
        logic [15:0] v;
        fib[0] = 16'd0;
        fib[1] = 16'd1;
        for (int i = 2; i < 16; i++) fib[i] = fib[i-1] + fib[i-2];

        do_op(OP_ADD, 5'd0, 5'd0, 16'h0002, 16'h0001, 1'b1, 1'b1, bus);
        n_checks++;
        if (bus !== fib[1]) begin
            n_fail++; $display("FAIL fib_bus R1: got %h expected %h", bus, fib[1]);
        end
        n_checks++;
        if (disp_value !== fib[1]) begin
            n_fail++; $display("FAIL fib_disp R1: got %h expected %h", disp_value, fib[1]);
        end
        for (int i = 2; i < 16; i++) begin
            do_op(OP_ADD, 5'(i-2), 5'(i-1), 16'(1 << i), 16'h0000, 1'b0, 1'b1, bus);
            n_checks++;
            if (bus !== fib[i]) begin
                n_fail++; $display("FAIL fib_bus R%0d: got %h expected %h", i, bus, fib[i]);
            end
            n_checks++;
            if (disp_value !== fib[i]) begin
                n_fail++; $display("FAIL fib_disp R%0d: got %h expected %h", i, disp_value, fib[i]);
            end
        end
        n_checks++;
        if (flags !== 5'b00000) begin
            n_fail++; $display("FAIL fib_flags: got %b expected %b", flags, 5'b00000);
        end
        peek_reg(15, v);
        n_checks++;
        if (v !== 16'h0262) begin
            n_fail++; $display("FAIL fib_R15: got %h expected %h", v, 16'h0262);
        end
    endtask

    // R1 holds operand A, results land in R2.
    task automatic test_overflow();
        logic [15:0] bus;
        logic [15:0] a_vals [5];
        logic [7:0]  ops    [5];
        logic [15:0] exp_bus[5];
        logic [4:0]  exp_fl [5];
        a_vals = '{16'h7FFF, 16'h0000, 16'h0001, 16'hFFFF, 16'h8000};
        ops    = '{OP_ADD,   OP_SUB,   OP_ADD,   OP_ADD,   OP_SUB};
        exp_bus= '{16'h8000, 16'hFFFF, 16'h0002, 16'h0000, 16'h7FFF};
        exp_fl = '{5'b00100, 5'b00001, 5'b00000, 5'b01001, 5'b00100};
        for (int k = 0; k < 5; k++) begin
            do_op(OP_MOV, 5'd0, 5'd0, 16'h0002, a_vals[k], 1'b1, 1'b1, bus);
            do_op(ops[k], 5'd1, 5'd0, 16'h0004, 16'h0001, 1'b1, 1'b1, bus);
            n_checks++;
            if (bus !== exp_bus[k]) begin
                n_fail++; $display("FAIL ovf_bus case%0d: got %h expected %h", k, bus, exp_bus[k]);
            end
            n_checks++;
            if (flags !== exp_fl[k]) begin
                n_fail++; $display("FAIL ovf_flags case%0d: got %b expected %b", k, flags, exp_fl[k]);
            end
            n_checks++;
            if (disp_value !== exp_bus[k]) begin
                n_fail++; $display("FAIL ovf_disp case%0d: got %h expected %h", k, disp_value, exp_bus[k]);
            end
        end
    endtask

    task automatic test_cmp();
        logic [15:0] bus;
        logic [15:0] v;
        do_op(OP_MOV, 5'd0, 5'd0, 16'h0010, 16'h0005, 1'b1, 1'b1, bus);
        do_op(OP_MOV, 5'd0, 5'd0, 16'h0020, 16'hFFF9, 1'b1, 1'b1, bus);

        do_op(OP_CMP, 5'd4, 5'd5, 16'hFFFF, 16'h0000, 1'b0, 1'b1, bus);
        n_checks++;
        if (flags !== 5'b00110) begin
            n_fail++; $display("FAIL cmp_lt_flags: got %b expected %b", flags, 5'b00110);
        end
        n_checks++;
        if (disp_value !== 16'hFFF9) begin
            n_fail++; $display("FAIL cmp_disp: got %h expected %h", disp_value, 16'hFFF9);
        end
        peek_reg(4, v);
        n_checks++;
        if (v !== 16'h0005) begin
            n_fail++; $display("FAIL cmp_R4: got %h expected %h", v, 16'h0005);
        end
        peek_reg(2, v);
        n_checks++;
        if (v !== 16'h7FFF) begin
            n_fail++; $display("FAIL cmp_R2: got %h expected %h", v, 16'h7FFF);
        end

        do_op(OP_CMP, 5'd5, 5'd4, 16'hFFFF, 16'h0000, 1'b0, 1'b1, bus);
        n_checks++;
        if (flags !== 5'b10100) begin
            n_fail++; $display("FAIL cmp_swap_flags: got %b expected %b", flags, 5'b10100);
        end
        peek_reg(5, v);
        n_checks++;
        if (v !== 16'hFFF9) begin
            n_fail++; $display("FAIL cmp_R5: got %h expected %h", v, 16'hFFF9);
        end

        do_op(OP_CMP, 5'd4, 5'd4, 16'h0000, 16'h0000, 1'b0, 1'b1, bus);
        n_checks++;
        if (flags !== 5'b01100) begin
            n_fail++; $display("FAIL cmp_eq_flags: got %b expected %b", flags, 5'b01100);
        end
    endtask

    task automatic test_gating();
        logic [15:0] bus;
        logic [15:0] v;
        do_op(OP_ADD, 5'd4, 5'd0, 16'h0004, 16'h0001, 1'b1, 1'b0, bus);
        n_checks++;
        if (bus !== 16'h0000) begin
            n_fail++; $display("FAIL gate_bus: got %h expected %h", bus, 16'h0000);
        end
        n_checks++;
        if (flags !== 5'b01100) begin
            n_fail++; $display("FAIL gate_flags: got %b expected %b", flags, 5'b01100);
        end
        peek_reg(2, v);
        n_checks++;
        if (v !== 16'h7FFF) begin
            n_fail++; $display("FAIL gate_R2: got %h expected %h", v, 16'h7FFF);
        end

        do_op(8'h7F, 5'd4, 5'd0, 16'h0004, 16'h0001, 1'b1, 1'b1, bus);
        n_checks++;
        if (bus !== 16'h0000) begin
            n_fail++; $display("FAIL badop_bus: got %h expected %h", bus, 16'h0000);
        end
        n_checks++;
        if (flags !== 5'b01100 || disp_value !== 16'hFFF9) begin
            n_fail++; $display("FAIL badop_state: got flags %b disp %h expected %b %h",
                               flags, disp_value, 5'b01100, 16'hFFF9);
        end
        peek_reg(2, v);
        n_checks++;
        if (v !== 16'h7FFF) begin
            n_fail++; $display("FAIL badop_R2: got %h expected %h", v, 16'h7FFF);
        end

        @(negedge clk);
        alu_op = 'x; muxA = 'x; muxB = 'x; regs_en = 'x; imm = 'x; imm_control = 'x;
        buff_en = 1'b0;
        @(posedge clk);
        #1 drive_idle();
        n_checks++;
        if (flags !== 5'b01100 || disp_value !== 16'hFFF9) begin
            n_fail++; $display("FAIL xgate_state: got flags %b disp %h expected %b %h",
                               flags, disp_value, 5'b01100, 16'hFFF9);
        end
        peek_reg(4, v);
        n_checks++;
        if (v !== 16'h0005) begin
            n_fail++; $display("FAIL xgate_R4: got %h expected %h", v, 16'h0005);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bus;
        logic [15:0] v;
        do_op(OP_MOV, 5'd0, 5'd0, 16'h8001, 16'h1234, 1'b1, 1'b1, bus);
        n_checks++;
        if (disp_value !== 16'h1234) begin
            n_fail++; $display("FAIL multi_disp: got %h expected %h", disp_value, 16'h1234);
        end
        do_op(OP_ADD, 5'd0, 5'd15, 16'h0002, 16'h0000, 1'b0, 1'b1, bus);
        n_checks++;
        if (bus !== 16'h2468) begin
            n_fail++; $display("FAIL fwd_bus: got %h expected %h", bus, 16'h2468);
        end
        // R1 = R1 + R1 reads the old R1 during its own write.
        do_op(OP_ADD, 5'd1, 5'd1, 16'h0002, 16'h0000, 1'b0, 1'b1, bus);
        n_checks++;
        if (bus !== 16'h48D0) begin
            n_fail++; $display("FAIL rdw_bus: got %h expected %h", bus, 16'h48D0);
        end
        peek_reg(0, v);
        n_checks++;
        if (v !== 16'h1234) begin
            n_fail++; $display("FAIL multi_R0: got %h expected %h", v, 16'h1234);
        end
        peek_reg(15, v);
        n_checks++;
        if (v !== 16'h1234) begin
            n_fail++; $display("FAIL multi_R15: got %h expected %h", v, 16'h1234);
        end
        peek_reg(1, v);
        n_checks++;
        if (v !== 16'h48D0) begin
            n_fail++; $display("FAIL rdw_R1: got %h expected %h", v, 16'h48D0);
        end
        n_checks++;
        if (flags !== 5'b00000) begin
            n_fail++; $display("FAIL b2b_flags: got %b expected %b", flags, 5'b00000);
        end
    endtask

    // Logic ops and shifts on R0 = 0x1234, results into R6; XOR last leaves Z=1.
    task automatic test_logic_ops();
        logic [15:0] bus;
        logic [7:0]  ops [5];
        logic [15:0] ims [5];
        logic [15:0] exp [5];
        ops = '{OP_AND,   OP_OR,    OP_LSH,   OP_LSH,   OP_XOR};
        ims = '{16'h00FF, 16'h0F00, 16'h0014, 16'h000C, 16'h1234};
        exp = '{16'h0034, 16'h1F34, 16'h2340, 16'h4000, 16'h0000};
        for (int k = 0; k < 5; k++) begin
            do_op(ops[k], 5'd0, 5'd0, 16'h0040, ims[k], 1'b1, 1'b1, bus);
            n_checks++;
            if (bus !== exp[k] || disp_value !== exp[k]) begin
                n_fail++; $display("FAIL logic case%0d: got bus %h disp %h expected %h",
                                   k, bus, disp_value, exp[k]);
            end
        end
        n_checks++;
        if (flags !== 5'b01000) begin
            n_fail++; $display("FAIL logic_xor_flags: got %b expected %b", flags, 5'b01000);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        @(negedge clk);
        alu_op = OP_MOV; imm = 16'hABCD; imm_control = 1'b1; regs_en = 16'h0008; buff_en = 1'b1;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (flags !== 5'b00000 || disp_value !== 16'h0000) begin
            n_fail++; $display("FAIL rst_async: got flags %b disp %h expected %b %h",
                               flags, disp_value, 5'b00000, 16'h0000);
        end
        @(posedge clk);
        #1 drive_idle();
        n_checks++;
        if (flags !== 5'b00000 || disp_value !== 16'h0000) begin
            n_fail++; $display("FAIL rst_edge_write: got flags %b disp %h expected %b %h",
                               flags, disp_value, 5'b00000, 16'h0000);
        end
        for (int i = 0; i < 16; i++) begin
            peek_reg(i, v);
            n_checks++;
            if (v !== 16'h0000) begin
                n_fail++; $display("FAIL rst_mid_reg R%0d: got %h expected %h", i, v, 16'h0000);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        test_fibonacci();
    endtask

    initial begin
        test_reset();
        test_fibonacci();
        test_overflow();
        test_cmp();
        test_gating();
        test_back_to_back();
        test_logic_ops();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
